bullet_pool_ctrl: RTL and testbench
===================================

# bullet_pool_ctrl

Parametrised multi-bullet enable controller for the shooter datapath. It tracks a pool of NUM_BULLETS bullet slots and allocates a free slot on each debounced fire press. A slot retires on collision or when it reaches the top row. It also enforces a fire cooldown and manages a finite magazine with manual and automatic reload. It sits between the player push-buttons and the per-bullet position/draw logic, replacing the single-bullet enable latch.

## Interface
- NUM_BULLETS, 4, number of bullet slots (1..16)
- Y_WIDTH, 10, width of each bullet Y coordinate
- TOP_Y, 40, Y value at which a bullet retires
- COOLDOWN, 8, cycles after a launch before another launch is accepted (0 = none)
- MAG_SIZE, 8, rounds per magazine (≥1)
- RELOAD_CYCLES, 64, reload duration in cycles (≥1)

- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- fire_n  in  1  fire push-button, active-low, asynchronous to clk
- reload_n  in  1  reload push-button, active-low, asynchronous to clk
- bullet_y  in  NUM_BULLETS*Y_WIDTH  packed Y positions; slot i is bits [i*Y_WIDTH +: Y_WIDTH]
- collision  in  NUM_BULLETS  per-slot hit flags, sampled each cycle
- enb  out  NUM_BULLETS  slot active (bullet moving and drawn)
- launch  out  NUM_BULLETS  one-cycle pulse that tells slot i to load its start position
- ammo  out  $clog2(MAG_SIZE+1)  rounds remaining
- reloading  out  1  reload in progress
- empty  out  1  combinational, ammo == 0

## Operation
- Reset values: enb=0, launch=0, ammo=MAG_SIZE, reloading=0, cooldown counter=0, reload counter=0, synchronisers=1 (released).
- Each of fire_n and reload_n passes through a 2-flop synchroniser. A press is a 1→0 transition of the synchronised signal, i.e. one event per press. Holding a button produces no further events.
- Fire accepted when all of these hold: press event, reloading=0, ammo>0, cooldown=0, and at least one slot has enb=0.
- On an accepted fire:
  - The lowest-index slot with enb=0 gets enb=1 and launch=1 for one cycle.
  - ammo decrements by 1.
  - The cooldown counter loads COOLDOWN.
- A fire press that is not accepted is dropped, not queued.
- The cooldown counter decrements by 1 per cycle while nonzero.
- Retire: slot i with enb=1 clears to 0 on the next edge if collision[i]=1 or bullet_y[i]==TOP_Y. Comparison is exact equality on Y_WIDTH bits. Collision or TOP_Y on a slot with enb=0 is ignored.
- Free-slot selection uses the current registered enb. A slot retiring this cycle is not reusable until the following cycle.
- Manual reload is accepted on a reload press when reloading=0 and ammo<MAG_SIZE. Otherwise it is ignored.
- Auto reload: on the edge where an accepted fire takes ammo from 1 to 0, reloading rises on that same edge.
- During a reload:
  - The reload counter runs RELOAD_CYCLES cycles.
  - On the final edge, reloading=0 and ammo=MAG_SIZE together.
  - Fire presses are dropped. Active bullets keep moving and retiring normally.
- Simultaneous fire and reload press in the same cycle: fire has priority if accepted, and the reload press is dropped. If the fire is not accepted, the reload is evaluated normally.
- Reset asserted mid-reload or mid-flight: everything returns to reset values immediately. Bullets are lost.

## Timing
- Fire latency: if k is the first clk edge that samples fire_n low, enb[i] and launch[i] rise at edge k+2.
- Reload latency: for a press sampled at edge k, reloading rises at edge k+2 and falls at edge k+2+RELOAD_CYCLES.
- launch is high for exactly one cycle, coincident with the enb rise.
- Retire latency: collision or TOP_Y sampled at edge t clears enb at edge t.
- Minimum spacing between launches is COOLDOWN+1 cycles, given distinct press events.
- ammo and reloading are registered. empty is combinational from ammo.

## Test plan
- Reset and single shot: release rst_n, press fire at edge 10 with COOLDOWN=0 → enb=4'b0001, launch pulse at edge 12, ammo 8→7. Drive bullet_y[0]=40 → enb[0]=0 on the next edge.
- Pool allocation: fire 4 times with cooldown satisfied → enb sequence 0001, 0011, 0111, 1111. A 5th press is dropped and ammo stays 4. Collide slot 1 → enb=1101, and the next press fills slot 1 → 1111.
- Cooldown: COOLDOWN=8, press at launch+3 → dropped. Press landing at launch+9 → accepted.
- Auto reload: MAG_SIZE=2, two launches → ammo=0 and reloading=1 on the second launch edge. A press during reload is dropped. After 64 cycles, ammo=2 and reloading=0.
- Manual reload and priority: with ammo=5, a reload press → ammo=8 after RELOAD_CYCLES. With ammo=8, a reload press is ignored. Simultaneous accepted fire and reload → launch occurs and reloading stays 0.
- Async reset mid-reload: assert rst_n=0 between clock edges while reloading=1 with enb=0011 → outputs immediately become enb=0, reloading=0, ammo=MAG_SIZE, without waiting for a clock edge.

Source files
------------

// File: rtl/bullet_pool_ctrl.sv
// bullet_pool_ctrl: allocates bullet slots on debounced fire presses, retires
// them on collision or when they reach the top row, and manages the fire
// cooldown and a finite magazine with manual and automatic reload.
module bullet_pool_ctrl #(
  parameter int NUM_BULLETS   = 4,
  parameter int Y_WIDTH       = 10,
  parameter int TOP_Y         = 40,
  parameter int COOLDOWN      = 8,
  parameter int MAG_SIZE      = 8,
  parameter int RELOAD_CYCLES = 64
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           fire_n,
  input  logic                           reload_n,
  input  logic [NUM_BULLETS*Y_WIDTH-1:0] bullet_y,
  input  logic [NUM_BULLETS-1:0]         collision,
  output logic [NUM_BULLETS-1:0]         enb,
  output logic [NUM_BULLETS-1:0]         launch,
  output logic [$clog2(MAG_SIZE+1)-1:0]  ammo,
  output logic                           reloading,
  output logic                           empty
);

  localparam int AW = $clog2(MAG_SIZE + 1);
  // A zero cooldown still needs a one-bit counter so the logic stays uniform.
  localparam int CW = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
  // The reload counter counts down from RELOAD_CYCLES-1 to 0.
  localparam int RW = (RELOAD_CYCLES > 1) ? $clog2(RELOAD_CYCLES) : 1;

  localparam logic [Y_WIDTH-1:0] TOP_Y_V   = Y_WIDTH'(TOP_Y);
  localparam logic [AW-1:0]      MAG_V     = AW'(MAG_SIZE);
  localparam logic [AW-1:0]      ONE_V     = AW'(1);
  localparam logic [CW-1:0]      CD_V      = CW'(COOLDOWN);
  localparam logic [RW-1:0]      RL_LAST_V = RW'(RELOAD_CYCLES - 1);

  typedef enum logic {
    ST_READY  = 1'b0,
    ST_RELOAD = 1'b1
  } state_t;

  state_t                 state, state_nx;
  logic [2:0]             fire_sh, reload_sh;
  logic                   fire_press, reload_press;
  logic [CW-1:0]          cd_cnt, cd_nx;
  logic [RW-1:0]          rl_cnt, rl_nx;
  logic [AW-1:0]          ammo_nx;
  logic [NUM_BULLETS-1:0] enb_nx, launch_nx, retire, slot_sel;
  logic                   slot_found, fire_ok, reload_ok;

  // Two synchroniser flops plus one history flop per button; a press is the
  // falling edge of the synchronised level, so a held button fires only once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fire_sh   <= 3'b111;
      reload_sh <= 3'b111;
    end else begin
      fire_sh   <= {fire_sh[1:0], fire_n};
      reload_sh <= {reload_sh[1:0], reload_n};
    end
  end

  assign fire_press   = fire_sh[2] & ~fire_sh[1];
  assign reload_press = reload_sh[2] & ~reload_sh[1];

  // Retire detection and lowest-index free slot search on the registered enb,
  // so a slot retiring this cycle cannot be handed out until the next one.
  always_comb begin
    retire     = '0;
    slot_sel   = '0;
    slot_found = 1'b0;
    for (int i = 0; i < NUM_BULLETS; i++) begin
      retire[i] = enb[i] & (collision[i] | (bullet_y[i*Y_WIDTH +: Y_WIDTH] == TOP_Y_V));
      if (!enb[i] && !slot_found) begin
        slot_sel[i] = 1'b1;
        slot_found  = 1'b1;
      end
    end
  end

  assign fire_ok   = fire_press && (state == ST_READY) && (ammo != '0) &&
                     (cd_cnt == '0) && slot_found;
  assign reload_ok = reload_press && (state == ST_READY) && (ammo != MAG_V) && !fire_ok;

  // Next-state logic: slot updates, cooldown, magazine and the reload FSM.
  always_comb begin
    state_nx  = state;
    ammo_nx   = ammo;
    rl_nx     = rl_cnt;
    cd_nx     = (cd_cnt != '0) ? cd_cnt - 1'b1 : cd_cnt;
    launch_nx = fire_ok ? slot_sel : '0;
    enb_nx    = (enb & ~retire) | launch_nx;
    unique case (state)
      ST_READY: begin
        if (fire_ok) begin
          ammo_nx = ammo - 1'b1;
          cd_nx   = CD_V;
          if (ammo == ONE_V) begin
            state_nx = ST_RELOAD;
            rl_nx    = RL_LAST_V;
          end
        end else if (reload_ok) begin
          state_nx = ST_RELOAD;
          rl_nx    = RL_LAST_V;
        end
      end
      ST_RELOAD: begin
        if (rl_cnt == '0) begin
          state_nx = ST_READY;
          ammo_nx  = MAG_V;
        end else begin
          rl_nx = rl_cnt - 1'b1;
        end
      end
      default: state_nx = ST_READY;
    endcase
  end

  // State register; reset drops every bullet and refills the magazine at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_READY;
      enb    <= '0;
      launch <= '0;
      ammo   <= MAG_V;
      cd_cnt <= '0;
      rl_cnt <= '0;
    end else begin
      state  <= state_nx;
      enb    <= enb_nx;
      launch <= launch_nx;
      ammo   <= ammo_nx;
      cd_cnt <= cd_nx;
      rl_cnt <= rl_nx;
    end
  end

  assign reloading = (state == ST_RELOAD);
  assign empty     = (ammo == '0);

endmodule

// File: tb/tb_bullet_pool_ctrl.sv
// Directed table-driven bench for bullet_pool_ctrl at its default parameters.
module tb_bullet_pool_ctrl;

  localparam int NB = 4;
  localparam int YW = 10;

  typedef enum logic [2:0] {OP_FIRE, OP_RELOAD, OP_BOTH, OP_HIT, OP_TOP, OP_WAIT} op_e;

  typedef struct {
    op_e        op;
    int         arg;
    logic [3:0] exp_launch;
    logic [3:0] exp_enb;
    int         exp_ammo;
    logic       exp_rel;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             fire_n = 1'b1;
  logic             reload_n = 1'b1;
  logic [NB*YW-1:0] bullet_y = '0;
  logic [NB-1:0]    collision = '0;
  logic [NB-1:0]    enb, launch;
  logic [3:0]       ammo;
  logic             reloading, empty;

  int checks = 0;
  int passed = 0;
  vec_t tbl[$];

  bullet_pool_ctrl dut (
    .clk(clk), .rst_n(rst_n), .fire_n(fire_n), .reload_n(reload_n),
    .bullet_y(bullet_y), .collision(collision), .enb(enb), .launch(launch),
    .ammo(ammo), .reloading(reloading), .empty(empty)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input op_e op, input int arg, input logic [3:0] l,
                              input logic [3:0] e, input int a, input logic r);
    vec_t v;
    v.op = op; v.arg = arg; v.exp_launch = l; v.exp_enb = e; v.exp_ammo = a; v.exp_rel = r;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int step, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("[TB] FAIL %s (step %0d): got %0h, expected %0h", name, step, act, exp);
  endtask

  task automatic applyStimulus(input vec_t v, input int step);
    case (v.op)
      OP_FIRE, OP_RELOAD, OP_BOTH: begin
        if (v.op != OP_RELOAD) fire_n = 1'b0;
        if (v.op != OP_FIRE) reload_n = 1'b0;
        repeat (3) tick();
        checkOutput("launch_pulse", step, int'(launch), int'(v.exp_launch));
        checkOutput("enb_at_launch", step, int'(enb), int'(v.exp_enb));
        checkOutput("ammo_at_launch", step, int'(ammo), v.exp_ammo);
        checkOutput("reloading_at_launch", step, int'(reloading), int'(v.exp_rel));
        fire_n = 1'b1;
        reload_n = 1'b1;
        tick();
      end
      OP_HIT: begin
        collision[v.arg] = 1'b1;
        tick();
        collision = '0;
      end
      OP_TOP: begin
        bullet_y[v.arg*YW +: YW] = 10'd40;
        tick();
        bullet_y = '0;
      end
      default: repeat (v.arg) tick();
    endcase
    checkOutput("launch_idle", step, int'(launch), 0);
    checkOutput("enb", step, int'(enb), int'(v.exp_enb));
    checkOutput("ammo", step, int'(ammo), v.exp_ammo);
    checkOutput("reloading", step, int'(reloading), int'(v.exp_rel));
    checkOutput("empty", step, int'(empty), (v.exp_ammo == 0) ? 1 : 0);
  endtask

  initial begin
    // Main directed sequence: allocation, retire, cooldown, reload, priority.
    tbl.push_back(mk(OP_FIRE,   0, 4'b0001, 4'b0001, 7, 1'b0));
    tbl.push_back(mk(OP_TOP,    0, 4'b0000, 4'b0000, 7, 1'b0));
    tbl.push_back(mk(OP_WAIT,   3, 4'b0000, 4'b0000, 7, 1'b0));
    tbl.push_back(mk(OP_FIRE,   0, 4'b0000, 4'b0000, 7, 1'b0));
    tbl.push_back(mk(OP_FIRE,   0, 4'b0001, 4'b0001, 6, 1'b0));
    tbl.push_back(mk(OP_WAIT,   5, 4'b0000, 4'b0001, 6, 1'b0));
    tbl.push_back(mk(OP_FIRE,   0, 4'b0010, 4'b0011, 5, 1'b0));
    tbl.push_back(mk(OP_WAIT,   5, 4'b0000, 4'b0011, 5, 1'b0));
    tbl.push_back(mk(OP_FIRE,   0, 4'b0100, 4'b0111, 4, 1'b0));
    tbl.push_back(mk(OP_WAIT,   5, 4'b0000, 4'b0111, 4, 1'b0));
    tbl.push_back(mk(OP_FIRE,   0, 4'b1000, 4'b1111, 3, 1'b0));
    tbl.push_back(mk(OP_WAIT,   5, 4'b0000, 4'b1111, 3, 1'b0));
    tbl.push_back(mk(OP_FIRE,   0, 4'b0000, 4'b1111, 3, 1'b0));
    tbl.push_back(mk(OP_HIT,    1, 4'b0000, 4'b1101, 3, 1'b0));
    tbl.push_back(mk(OP_FIRE,   0, 4'b0010, 4'b1111, 2, 1'b0));
    tbl.push_back(mk(OP_RELOAD, 0, 4'b0000, 4'b1111, 2, 1'b1));
    tbl.push_back(mk(OP_HIT,    3, 4'b0000, 4'b0111, 2, 1'b1));
    tbl.push_back(mk(OP_WAIT,   4, 4'b0000, 4'b0111, 2, 1'b1));
    tbl.push_back(mk(OP_FIRE,   0, 4'b0000, 4'b0111, 2, 1'b1));
    tbl.push_back(mk(OP_TOP,    0, 4'b0000, 4'b0110, 2, 1'b1));
    tbl.push_back(mk(OP_WAIT,  52, 4'b0000, 4'b0110, 2, 1'b1));
    tbl.push_back(mk(OP_WAIT,   1, 4'b0000, 4'b0110, 8, 1'b0));
    tbl.push_back(mk(OP_RELOAD, 0, 4'b0000, 4'b0110, 8, 1'b0));
    tbl.push_back(mk(OP_FIRE,   0, 4'b0001, 4'b0111, 7, 1'b0));
    tbl.push_back(mk(OP_WAIT,   5, 4'b0000, 4'b0111, 7, 1'b0));
    tbl.push_back(mk(OP_BOTH,   0, 4'b1000, 4'b1111, 6, 1'b0));
    tbl.push_back(mk(OP_WAIT,   5, 4'b0000, 4'b1111, 6, 1'b0));
    tbl.push_back(mk(OP_BOTH,   0, 4'b0000, 4'b1111, 6, 1'b1));

    #12;
    checkOutput("reset_enb", -1, int'(enb), 0);
    checkOutput("reset_launch", -1, int'(launch), 0);
    checkOutput("reset_ammo", -1, int'(ammo), 8);
    checkOutput("reset_reloading", -1, int'(reloading), 0);
    checkOutput("reset_empty", -1, int'(empty), 0);
    rst_n = 1'b1;
    repeat (2) tick();

    for (int i = 0; i < tbl.size(); i++) applyStimulus(tbl[i], i);

    // Asynchronous reset between edges while reloading with bullets in flight.
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_enb", 100, int'(enb), 0);
    checkOutput("async_rst_reloading", 100, int'(reloading), 0);
    checkOutput("async_rst_ammo", 100, int'(ammo), 8);
    checkOutput("async_rst_launch", 100, int'(launch), 0);
    #3;
    rst_n = 1'b1;
    repeat (3) tick();

    // Empty the magazine; the last launch starts the automatic reload.
    for (int n = 0; n < 8; n++) begin
      applyStimulus(mk(OP_FIRE, 0, 4'b0001, 4'b0001, 7 - n, (n == 7)), 200 + 3*n);
      applyStimulus(mk(OP_HIT,  0, 4'b0000, 4'b0000, 7 - n, (n == 7)), 201 + 3*n);
      applyStimulus(mk(OP_WAIT, 5, 4'b0000, 4'b0000, 7 - n, (n == 7)), 202 + 3*n);
    end
    applyStimulus(mk(OP_FIRE,  0, 4'b0000, 4'b0000, 0, 1'b1), 300);
    applyStimulus(mk(OP_WAIT, 52, 4'b0000, 4'b0000, 0, 1'b1), 301);
    applyStimulus(mk(OP_WAIT,  1, 4'b0000, 4'b0000, 8, 1'b0), 302);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
